led_scan_arbiter: RTL and testbench
===================================

LED_SCAN_ARBITER -- requirements
Module: led_scan_arbiter

Interface
REQ-001 Parameter DWELL, default 2000, clock cycles each pixel is held on LEDout (legal range 1..4194303).
REQ-002 Parameter BLANK, default 1, number of DWELL-length blank periods inserted after each object (legal range 0..7).
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RSTn  input  1  asynchronous, active-low reset.
REQ-005 obj_en  input  4  per-object display request; bit i enables object i.
REQ-006 obj_color  input  8  object i colour code in bits [2i+1:2i].
REQ-007 obj_row  input  16  object i row (0..15) in bits [4i+3:4i].
REQ-008 obj_col  input  12  object i start column (0..7) in bits [3i+2:3i].
REQ-009 obj_len  input  8  object i horizontal length in pixels (0..3) in bits [2i+1:2i].
REQ-010 LEDout  output  10  pixel word {color[1:0], 1'b0, row[3:0], col[2:0]}; 10'b0 means blank.
REQ-011 slot_id  output  2  index of the object currently latched.
REQ-012 frame_start  output  1  one-cycle pulse marking the start of a new scan round.

Function
REQ-013 An object is eligible when obj_en[i]=1 and obj_len[i]!=0; other objects are skipped with no time spent on them.
REQ-014 FSM states: IDLE, LOAD, SHOW, GAP.
REQ-015 IDLE: LEDout=0; move to LOAD on the first cycle any object is eligible.
REQ-016 LOAD (exactly 1 cycle): select the eligible object by round-robin search starting at (last_served+1) mod 4; latch its colour, row, column and length; LEDout=0; go to SHOW; if nothing is eligible, go to IDLE.
REQ-017 The latched descriptor is used for the whole object; input changes during SHOW/GAP take effect at the next LOAD only.
REQ-018 SHOW: pixel k (k=0..len-1) is driven as {color,0,row,col+k} for exactly DWELL cycles, then k increments.
REQ-019 Column clipping: computed with a 4-bit sum; when col+k>7, SHOW ends immediately and no pixel is emitted for that k or beyond.
REQ-020 After the last emitted pixel, go to GAP if BLANK>0, else directly to LOAD.
REQ-021 GAP: LEDout=0 for BLANK*DWELL cycles, then LOAD.
REQ-022 slot_id updates in the LOAD cycle and holds until the next LOAD.
REQ-023 frame_start pulses in a LOAD cycle whose selected index is less than or equal to the previously served index, or that is the first LOAD after IDLE or reset.
REQ-024 Each dwell count restarts at 0 on every pixel, GAP period and state entry; no count carries across objects.
REQ-025 De-asserting obj_en of the active object does not truncate it; the object completes per REQ-017.
REQ-026 Single eligible object: it is re-selected every round and frame_start pulses at every LOAD.

Reset
REQ-027 When RSTn=0, asynchronously: state=IDLE, LEDout=0, slot_id=0, frame_start=0, last_served=3 so the first search begins at object 0, dwell counter=0, pixel index=0, latched descriptor=0.
REQ-028 Reset asserted mid-SHOW or mid-GAP forces LEDout to 0 within the same cycle; scanning restarts from object 0 after release.

Verification (DWELL=4, BLANK=1)
REQ-029 obj_en=0001, obj0 color=2, row=13, col=2, len=3 -> LOAD 1 cycle, LEDout=0x26A,0x26B,0x26C for 4 cycles each, 4 cycles of 0, repeat; frame_start at every LOAD.
REQ-030 obj_en=0111 with all three eligible -> order 0,1,2,0...; frame_start only on LOADs selecting object 0; slot_id follows the same sequence.
REQ-031 obj0 col=6, len=3 -> pixels at columns 6 and 7 only (8 cycles), then GAP; no column-0 wrap.
REQ-032 obj_len[1]=0 with obj_en=0011 -> object 1 never shown; object 0 served back-to-back with frame_start every LOAD.
REQ-033 Change obj_row[0] from 13 to 2 during SHOW of object 0 -> current object keeps row 13; the next LOAD uses row 2.
REQ-034 RSTn pulsed low during the second pixel of object 1 -> LEDout=0 at once; after release the first LOAD selects object 0 with frame_start=1.

Source files
------------

// File: rtl/led_scan_arbiter.sv
// led_scan_arbiter: round-robin LED scanner, shows up to four horizontal objects one pixel per DWELL cycles
//   CLK, RSTn            : clock, asynchronous active-low reset
//   obj_en/color/row/col/len : packed per-object descriptors (object i in slice i)
//   LEDout               : {color, 1'b0, row, col}; zero while blank
//   slot_id              : index of the object latched at the most recent LOAD
//   frame_start          : one-cycle pulse during a LOAD that begins a new scan round
module led_scan_arbiter #(
  parameter int DWELL = 2000,
  parameter int BLANK = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [3:0]  obj_en,
  input  logic [7:0]  obj_color,
  input  logic [15:0] obj_row,
  input  logic [11:0] obj_col,
  input  logic [7:0]  obj_len,
  output logic [9:0]  LEDout,
  output logic [1:0]  slot_id,
  output logic        frame_start
);
  typedef enum logic [1:0] {IDLE, LOAD, SHOW, GAP} state_t;
  localparam logic [21:0] DW_MAX = 22'(DWELL - 1);
  state_t      state_q;
  logic [21:0] dwell_q;
  logic [2:0]  gap_q;
  logic [1:0]  k_q, last_q, color_q, len_q;
  logic [3:0]  row_q;
  logic [2:0]  col_q;
  logic [3:0]  elig;
  logic [1:0]  sel;
  logic [3:0]  col_nxt;
  logic        dwell_done, last_pix, pick;
  // Descending search so the nearest index after last_q wins; j=4 wraps back to last_q itself.
  always_comb begin
    for (int i = 0; i < 4; i++) elig[i] = obj_en[i] && obj_len[2*i +: 2] != 2'd0;
    sel = last_q;
    for (int j = 4; j >= 1; j--) sel = elig[last_q + 2'(j)] ? last_q + 2'(j) : sel;
  end
  assign dwell_done = dwell_q == DW_MAX;
  assign col_nxt    = {1'b0, col_q} + {2'b00, k_q} + 4'd1;
  // Object ends after the last requested pixel or when the next column would leave the 0..7 range.
  assign last_pix   = (k_q + 2'd1 == len_q) || col_nxt[3];
  // Selection happens on the edge entering LOAD so slot_id and frame_start are visible during LOAD.
  assign pick       = state_q == IDLE
                   || (state_q == SHOW && dwell_done && last_pix && BLANK == 0)
                   || (state_q == GAP && dwell_done && gap_q == 3'(BLANK - 1));
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      gap_q       <= '0;
      k_q         <= '0;
      last_q      <= 2'd3;
      color_q     <= '0;
      len_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      LEDout      <= '0;
      slot_id     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pick) begin
        LEDout  <= '0;
        dwell_q <= '0;
        if (|elig) begin
          state_q     <= LOAD;
          slot_id     <= sel;
          last_q      <= sel;
          frame_start <= state_q == IDLE || sel <= last_q;
          color_q     <= obj_color[2*sel +: 2];
          row_q       <= obj_row[4*sel +: 4];
          col_q       <= obj_col[3*sel +: 3];
          len_q       <= obj_len[2*sel +: 2];
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          LOAD: begin
            state_q <= SHOW;
            k_q     <= '0;
            LEDout  <= {color_q, 1'b0, row_q, col_q};
          end
          SHOW: begin
            if (!dwell_done) begin
              dwell_q <= dwell_q + 22'd1;
            end else if (!last_pix) begin
              dwell_q <= '0;
              k_q     <= k_q + 2'd1;
              LEDout  <= {color_q, 1'b0, row_q, col_nxt[2:0]};
            end else begin
              state_q <= GAP;
              dwell_q <= '0;
              gap_q   <= '0;
              LEDout  <= '0;
            end
          end
          GAP: begin
            dwell_q <= dwell_done ? '0 : dwell_q + 22'd1;
            gap_q   <= dwell_done ? gap_q + 3'd1 : gap_q;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_scan_arbiter.sv
// tb_led_scan_arbiter: randomized self-checking bench for led_scan_arbiter against a per-object output-stream model
module tb_led_scan_arbiter;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  logic        CLK, RSTn;
  logic [3:0]  obj_en;
  logic [7:0]  obj_color, obj_len;
  logic [15:0] obj_row;
  logic [11:0] obj_col;
  logic [9:0]  LEDout;
  logic [1:0]  slot_id;
  logic        frame_start;
  typedef struct packed {logic [9:0] led; logic [1:0] slot; logic fs;} exp_t;
  exp_t q[$];
  exp_t e;
  int   m_last;
  logic [1:0] m_slot;
  bit   m_idle;
  int   vectors, errors;
  led_scan_arbiter #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .CLK(CLK), .RSTn(RSTn), .obj_en(obj_en), .obj_color(obj_color), .obj_row(obj_row),
    .obj_col(obj_col), .obj_len(obj_len), .LEDout(LEDout), .slot_id(slot_id), .frame_start(frame_start)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic model_reset();
    q.delete();
    m_last = 3;
    m_slot = 2'd0;
    m_idle = 1'b1;
  endtask
  // When the previous object's output stream is used up, pick the next object from the current
  // inputs and queue its whole output sequence: one LOAD cycle, the visible pixels, the blank time.
  task automatic model_step();
    if (q.size() == 0) begin
      int p;
      p = -1;
      for (int d = 1; d <= 4; d++) begin
        int i;
        i = (m_last + d) % 4;
        if (p < 0 && obj_en[i] && obj_len[2*i +: 2] != 2'd0) p = i;
      end
      if (p < 0) begin
        q.push_back({10'd0, m_slot, 1'b0});
        m_idle = 1'b1;
      end else begin
        int c, n;
        logic [1:0] clr;
        logic [3:0] r;
        c   = int'(obj_col[3*p +: 3]);
        n   = int'(obj_len[2*p +: 2]);
        clr = obj_color[2*p +: 2];
        r   = obj_row[4*p +: 4];
        q.push_back({10'd0, 2'(p), m_idle || p <= m_last});
        for (int k = 0; k < n && c + k <= 7; k++)
          repeat (DWELL) q.push_back({clr, 1'b0, r, 3'(c + k), 2'(p), 1'b0});
        repeat (BLANK * DWELL) q.push_back({10'd0, 2'(p), 1'b0});
        m_last = p;
        m_slot = 2'(p);
        m_idle = 1'b0;
      end
    end
    e = q.pop_front();
  endtask
  task automatic advance();
    @(posedge CLK);
    if (!RSTn) begin
      model_reset();
      e = '0;
    end else model_step();
    @(negedge CLK);
  endtask
  task automatic set_obj(input int i, input logic en, input logic [1:0] c, input logic [3:0] r,
                         input logic [2:0] col, input logic [1:0] len);
    obj_en[i]          = en;
    obj_color[2*i +: 2] = c;
    obj_row[4*i +: 4]   = r;
    obj_col[3*i +: 3]   = col;
    obj_len[2*i +: 2]   = len;
  endtask
  task automatic test_reset();
    RSTn = 1'b0;
    obj_en = '0; obj_color = '0; obj_row = '0; obj_col = '0; obj_len = '0;
    model_reset();
    #1;
    vectors++;
    if ({LEDout, slot_id, frame_start} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async: got %h/%0d/%0b exp 000/0/0", LEDout, slot_id, frame_start);
    end
    repeat (3) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL reset_hold: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
    end
    RSTn = 1'b1;
    repeat (4) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL idle_none: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
    end
  endtask
  task automatic test_single();
    bit seen;
    seen = 0;
    set_obj(0, 1'b1, 2'd2, 4'd13, 3'd2, 2'd3);
    repeat (60) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL single: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
      if (LEDout == 10'h26C) seen = 1;
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL single_pixel26c: got never exp seen");
    end
  endtask
  task automatic test_round_robin();
    for (int i = 0; i < 3; i++)
      set_obj(i, 1'b1, 2'($urandom), 4'($urandom), 3'($urandom_range(0, 5)), 2'($urandom_range(1, 3)));
    set_obj(3, 1'b0, 2'd3, 4'd7, 3'd1, 2'd2);
    repeat (150) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL round_robin: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
    end
  endtask
  task automatic test_clip();
    obj_en = '0;
    set_obj(0, 1'b1, 2'd1, 4'd5, 3'd6, 2'd3);
    repeat (60) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL clip: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
      vectors++;
      if (LEDout != 10'd0 && LEDout[2:0] < 3'd6 && slot_id == 2'd0 && obj_col[2:0] == 3'd6) begin
        errors++;
        $display("FAIL clip_wrap: got col %0d exp col 6 or 7", LEDout[2:0]);
      end
    end
  endtask
  task automatic test_len_zero();
    set_obj(0, 1'b1, 2'd3, 4'd9, 3'd0, 2'd1);
    set_obj(1, 1'b1, 2'd2, 4'd4, 3'd3, 2'd0);
    repeat (60) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL len_zero: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
    end
  endtask
  task automatic test_mid_change();
    bit done, saw2;
    done = 0;
    saw2 = 0;
    obj_en = '0;
    set_obj(0, 1'b1, 2'd2, 4'd13, 3'd1, 2'd3);
    for (int t = 0; t < 100 && !done; t++) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL row_change_pre: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
      if (e.led != 10'd0) done = 1;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL row_change_wait: got timeout exp SHOW");
    end
    obj_row[3:0] = 4'd2;
    repeat (50) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL row_change: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
      if (LEDout != 10'd0 && LEDout[6:3] == 4'd2) saw2 = 1;
    end
    vectors++;
    if (!saw2) begin
      errors++;
      $display("FAIL row_change_next: got no row 2 exp row 2");
    end
  endtask
  task automatic test_reset_mid();
    bit found;
    found = 0;
    obj_en = '0;
    set_obj(0, 1'b1, 2'd1, 4'd3, 3'd0, 2'd2);
    set_obj(1, 1'b1, 2'd3, 4'd8, 3'd1, 2'd3);
    for (int t = 0; t < 200 && !found; t++) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL reset_mid_pre: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
      if (e.slot == 2'd1 && e.led != 10'd0 && e.led[2:0] == 3'd2) found = 1;
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait: got timeout exp obj1 pixel1");
    end
    RSTn = 1'b0;
    #1;
    vectors++;
    if ({LEDout, slot_id, frame_start} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h/%0d/%0b exp 000/0/0", LEDout, slot_id, frame_start);
    end
    advance();
    RSTn = 1'b1;
    advance();
    vectors++;
    if ({LEDout, slot_id, frame_start} !== e || slot_id !== 2'd0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_first_load: got %h/%0d/%0b exp 000/0/1", LEDout, slot_id, frame_start);
    end
    repeat (40) begin
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL reset_mid_post: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
    end
  endtask
  task automatic test_random();
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) begin
        obj_en    = 4'($urandom);
        obj_color = 8'($urandom);
        obj_row   = 16'($urandom);
        obj_col   = 12'($urandom);
        obj_len   = 8'($urandom);
      end
      advance();
      vectors++;
      if ({LEDout, slot_id, frame_start} !== e) begin
        errors++;
        $display("FAIL random: got %h/%0d/%0b exp %h/%0d/%0b", LEDout, slot_id, frame_start, e.led, e.slot, e.fs);
      end
    end
  endtask
  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_clip();
    test_len_zero();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
